conv_sample_source: RTL and testbench

CONV_SAMPLE_SOURCE -- requirements
Module: conv_sample_source

---
 rtl/conv_settings_pkg.sv | 24 ++
 rtl/conv_lfsr.sv | 30 +++
 rtl/conv_sample_source.sv | 110 +++++++++++
 tb/tb_conv_sample_source.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/conv_settings_pkg.sv
// Shared settings for the convolution sample source.
// Holds the FSM state type, LFSR seed and tap mask, default burst geometry,
// and the single-step LFSR function used by conv_lfsr.
package conv_settings_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH  = 16;
  localparam int unsigned DEF_DATA_CYCLES = 40;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1:
  // feedback = s[0]^s[2]^s[3]^s[5], shifted in at bit 15.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/conv_lfsr.sv
// 16-bit Fibonacci LFSR for the sample source.
// Ports: clk, reset (async, active high, restores seed), load (reseed),
//        advance (one step), state (current 16-bit register).
// load has priority over advance.
module conv_lfsr
  import conv_settings_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load)         state_d = LFSR_SEED;
    else if (advance) state_d = lfsr_step(state_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= LFSR_SEED;
    else       state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/conv_sample_source.sv
// Burst sample source feeding the convolution core.
// On a one-cycle start (accepted only when idle) it streams DATA_CYCLES
// samples over a valid/ready handshake, flags the final one with out_last,
// pulses done for one cycle after it, and keeps a running checksum in sum.
// Ports: clk, reset (async, active high), start, out_ready in;
//        out_valid, out_data, out_last, busy, done, sum out.
// Build option: define CONV_SRC_LFSR_EN to emit LFSR samples instead of a
// ramp (sample k = k). Ports are identical in both builds.
module conv_sample_source
  import conv_settings_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned DATA_CYCLES = DEF_DATA_CYCLES,
  parameter int unsigned SUM_WIDTH   = DATA_WIDTH + 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [SUM_WIDTH-1:0]  sum
);

  localparam int unsigned CNT_W = (DATA_CYCLES > 1) ? $clog2(DATA_CYCLES) : 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] sample;
  logic                 run, is_last, xfer;

  assign run     = (state_q == S_RUN);
  assign is_last = (cnt_q == CNT_W'(DATA_CYCLES - 1));
  assign xfer    = run && out_ready;

`ifdef CONV_SRC_LFSR_EN
  logic [15:0] lfsr_state;
  logic        lfsr_load, lfsr_adv;

  assign lfsr_load = (state_q == S_IDLE) && start;
  assign lfsr_adv  = xfer;

  conv_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .state   (lfsr_state)
  );

  assign sample = lfsr_state[DATA_WIDTH-1:0];
`else
  // Ramp: the sample is the burst index itself (wraps at 2^DATA_WIDTH).
  assign sample = DATA_WIDTH'(cnt_q);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      S_RUN: begin
        if (out_ready) begin
          sum_d = sum_q + SUM_WIDTH'(sample);
          if (is_last) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

  // Data is gated to zero outside RUN so idle/reset outputs read as 0
  // even though the LFSR rests at its non-zero seed.
  assign out_valid = run;
  assign out_data  = run ? sample : '0;
  assign out_last  = run && is_last;
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign sum       = sum_q;

endmodule

// File: tb/tb_conv_sample_source.sv
// Scoreboard bench for conv_sample_source: stimulus pushes expected samples
// and burst checksums into queues, a negedge monitor pops and compares.
module tb_conv_sample_source;

  localparam int DW = 16;
  localparam int NC = 40;
  localparam int SW = DW + 10;

  logic          clk = 1'b0;
  logic          reset, start, out_ready;
  logic          out_valid, out_last, busy, done;
  logic [DW-1:0] out_data;
  logic [SW-1:0] sum;

  logic          start1, ready1;
  logic          valid1, last1, busy1, done1;
  logic [DW-1:0] data1;
  logic [SW-1:0] sum1;

  always #5 clk = ~clk;

  conv_sample_source #(.DATA_WIDTH(DW), .DATA_CYCLES(NC), .SUM_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .sum(sum)
  );

  conv_sample_source #(.DATA_WIDTH(DW), .DATA_CYCLES(1), .SUM_WIDTH(SW)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .out_ready(ready1),
    .out_valid(valid1), .out_data(data1), .out_last(last1),
    .busy(busy1), .done(done1), .sum(sum1)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  logic [SW-1:0] dq[$];
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Independent model of the sample pattern: taps 16,14,13,11 written out.
  function automatic logic [15:0] model_sample(input int k);
`ifdef CONV_SRC_LFSR_EN
    logic [15:0] s = 16'hACE1;
    for (int i = 0; i < k; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    return s;
`else
    return 16'(k);
`endif
  endfunction

  task automatic push_burst();
    logic [SW-1:0] acc = '0;
    exp_t e;
    for (int k = 0; k < NC; k++) begin
      e.data = model_sample(k);
      e.last = (k == NC - 1);
      acc    = acc + SW'(e.data);
      sb.push_back(e);
    end
    dq.push_back(acc);
  endtask

  task automatic issue();
    @(posedge clk); #1 start = 1'b1;
    push_burst();
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_quiet(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      if (sb.size() == 0 && dq.size() == 0) break;
    end
    if (sb.size() != 0 || dq.size() != 0)
      check("burst_timeout", 32'(sb.size() + dq.size()), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  // Monitor: compares the shown sample every valid cycle (so stalls verify
  // the hold), pops on transfer, and checks the checksum on each done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_sample", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          check("out_data", 32'(out_data), 32'(sb[0].data));
          check("out_last", 32'(out_last), 32'(sb[0].last));
`ifdef CONV_SRC_LFSR_EN
          check("lfsr_nonzero", 32'(out_data != 0), 32'd1);
`endif
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (done) begin
        if (dq.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else check("done_sum", 32'(sum), 32'(dq.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b1; start1 = 1'b0; ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_last",  32'(out_last),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_sum",   32'(sum),       32'd0);

    // Plain burst, ready always high.
    issue();
    check("run_busy", 32'(busy), 32'd1);
    wait_quiet(100);
`ifndef CONV_SRC_LFSR_EN
    check("sum_held_780", 32'(sum), 32'd780);
`endif
    check("idle_busy", 32'(busy), 32'd0);

    // Backpressure while sample 5 is shown.
    issue();
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_quiet(100);

    // start re-pulsed mid-burst and in the DONE cycle: both ignored.
    issue();
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      check("done_seen", 32'(seen), 32'd1);
    end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_quiet(100);
    repeat (5) @(posedge clk);
    #1 check("ignored_start_idle", 32'(busy), 32'd0);

    // Reset after transfer 10.
    issue();
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data",  32'(out_data),  32'd0);
    check("mid_rst_busy",  32'(busy),      32'd0);
    check("mid_rst_sum",   32'(sum),       32'd0);
    sb.delete();
    dq.delete();
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("post_rst_valid", 32'(out_valid), 32'd0);
    issue();
    wait_quiet(100);

    // Single-sample burst instance.
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    check("one_valid", 32'(valid1), 32'd1);
    check("one_data",  32'(data1),  32'(model_sample(0)));
    check("one_last",  32'(last1),  32'd1);
    @(posedge clk); #1;
    check("one_done",  32'(done1),  32'd1);
    check("one_sum",   32'(sum1),   32'(model_sample(0)));
    check("one_valid_off", 32'(valid1), 32'd0);
    @(posedge clk); #1;
    check("one_done_off", 32'(done1), 32'd0);
    check("one_idle", 32'(busy1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
